data_bus_ctrl: RTL

DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

---
 rtl/data_bus_ctrl_pkg.sv | 24 ++
 rtl/data_bus_ctrl_mmio_timer.sv | 46 ++++
 rtl/data_bus_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/data_bus_ctrl_pkg.sv
// Shared definitions for the data bus controller: bus width, CB encodings,
// MMIO register offsets and STATUS bit positions.
package data_bus_ctrl_pkg;

    localparam int unsigned WORD = 64;

    typedef enum logic [1:0] {
        CB_IDLE    = 2'b00,
        CB_READ    = 2'b01,
        CB_WRITE   = 2'b10,
        CB_ILLEGAL = 2'b11
    } cb_e;

    localparam logic [4:0] OFF_CYCLE  = 5'h00;
    localparam logic [4:0] OFF_CMP    = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h18;

    localparam int unsigned ST_PENDING  = 0;
    localparam int unsigned ST_MISALIGN = 1;
    localparam int unsigned ST_ILLEGAL  = 2;
    localparam int unsigned ST_RANGE    = 3;

endpackage

// File: rtl/data_bus_ctrl_mmio_timer.sv
// Free-running CYCLE counter with CMP match, enable and sticky pending flag.
module mmio_timer
    import data_bus_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cmp_we,
    input  logic            ctrl_we,
    input  logic            pend_clr,
    input  logic [WORD-1:0] wdata,
    output logic [WORD-1:0] cycle,
    output logic [WORD-1:0] cmp,
    output logic            enable,
    output logic            pending
);

    logic match;

    // Match uses pre-edge CYCLE/CMP/enable, so a CMP write lands next cycle.
    always_comb begin
        match = enable && (cycle == cmp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle   <= '0;
            cmp     <= '0;
            enable  <= 1'b0;
            pending <= 1'b0;
        end else begin
            cycle <= cycle + 1'b1;
            if (cmp_we) begin
                cmp <= wdata;
            end
            if (ctrl_we) begin
                enable <= wdata[0];
            end
            if (match) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// Zero-latency data bus controller: word memory plus a 32-byte MMIO window
// (CYCLE, CMP, CTRL, STATUS) on a shared bidirectional data bus.
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int unsigned     DEPTH     = 128,
    parameter logic [WORD-1:0] MMIO_BASE = 64'h0000_0000_0001_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] DAB,
    inout  wire  [WORD-1:0] DDB,
    input  logic [1:0]      CB,
    output logic            irq,
    output logic            err
);

    localparam int unsigned     AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD-1:0] MEM_BYTES = WORD'(DEPTH) << 3;

    cb_e             cb;
    logic [WORD-1:0] mem [DEPTH];
    logic [WORD-1:0] mmio_off;
    logic [WORD-1:0] rdata;
    logic            access, in_mem, in_mmio, misalign, out_range;
    logic            wr_ok, mem_we, mmio_we;
    logic            cmp_we, ctrl_we, status_we, pend_clr;
    logic [3:1]      err_bits, err_set, err_clr;
    logic [WORD-1:0] cycle, cmp;
    logic            enable, pending;

    assign cb = cb_e'(CB);

    always_comb begin
        access    = (cb == CB_READ) || (cb == CB_WRITE);
        mmio_off  = DAB - MMIO_BASE;
        in_mem    = DAB < MEM_BYTES;
        in_mmio   = (DAB >= MMIO_BASE) && (mmio_off < WORD'(32));
        misalign  = access && (DAB[2:0] != 3'b000);
        out_range = access && !in_mem && !in_mmio;
        wr_ok     = (cb == CB_WRITE) && !misalign && !out_range;
        // Memory wins should the MMIO window ever overlap the array.
        mem_we    = wr_ok && in_mem;
        mmio_we   = wr_ok && !in_mem && in_mmio;
        cmp_we    = mmio_we && (mmio_off[4:0] == OFF_CMP);
        ctrl_we   = mmio_we && (mmio_off[4:0] == OFF_CTRL);
        status_we = mmio_we && (mmio_off[4:0] == OFF_STATUS);
        pend_clr  = (ctrl_we && DDB[1]) || (status_we && DDB[ST_PENDING]);
    end

    always_comb begin
        err_set              = '0;
        err_set[ST_MISALIGN] = misalign;
        err_set[ST_ILLEGAL]  = (cb == CB_ILLEGAL);
        err_set[ST_RANGE]    = out_range;
        err_clr              = status_we ? DDB[3:1] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_bits <= '0;
        end else begin
            err_bits <= err_set | (err_bits & ~err_clr);
        end
    end

    // Array is deliberately not reset; a write under reset is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[DAB[AW+2:3]] <= DDB;
        end
    end

    mmio_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .cmp_we   (cmp_we),
        .ctrl_we  (ctrl_we),
        .pend_clr (pend_clr),
        .wdata    (DDB),
        .cycle    (cycle),
        .cmp      (cmp),
        .enable   (enable),
        .pending  (pending)
    );

    always_comb begin
        rdata = '0;
        if (!misalign && !out_range) begin
            if (in_mem) begin
                rdata = mem[DAB[AW+2:3]];
            end else begin
                case (mmio_off[4:0])
                    OFF_CYCLE:  rdata = cycle;
                    OFF_CMP:    rdata = cmp;
                    OFF_CTRL:   rdata = {{(WORD-1){1'b0}}, enable};
                    OFF_STATUS: rdata = {{(WORD-4){1'b0}}, err_bits, pending};
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign DDB = ((cb == CB_READ) && !rst) ? rdata : 'z;
    assign irq = pending & enable;
    assign err = |err_bits;

endmodule
